// File: rtl/mcycle_controller.sv
// Multi-cycle control FSM for an RV32I subset: sequences fetch, decode, memory, ALU and jump steps.
// Moore outputs except FETCH/BRANCH write enables; a per-access watchdog traps stalled memory waits.
module mcycle_controller #(
  parameter bit EXT_EN  = 1'b0,
  parameter int TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic [6:0] i_operand,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7bit5,
  input  logic       i_zeroFlag,
  input  logic       i_memReady,
  output logic       o_memReq,
  output logic       o_memWriteEn,
  output logic       o_addressSrc,
  output logic       o_instructionRegWrite,
  output logic       o_pcWriteEn,
  output logic       o_regWriteEn,
  output logic [1:0] o_resultSel,
  output logic [1:0] o_aluInputASel,
  output logic [1:0] o_aluInputBSel,
  output logic [3:0] o_aluLogicOperation,
  output logic       o_illegal,
  output logic       o_memTimeout,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;
  localparam logic [1:0] A_PC       = 2'd0;
  localparam logic [1:0] A_OLDPC    = 2'd1;
  localparam logic [1:0] A_RD1      = 2'd2;
  localparam logic [1:0] A_ZERO     = 2'd3;
  localparam logic [1:0] B_RD2      = 2'd0;
  localparam logic [1:0] B_IMM      = 2'd1;
  localparam logic [1:0] B_FOUR     = 2'd2;

  // Counter only has to reach TIMEOUT-1: the limit is detected on the last waiting cycle.
  localparam int             CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            tmo_q, tmo_d;

  state_e          decode_nxt;
  logic            alu_f3_ok;
  logic [3:0]      exec_op;
  logic            mem_wait;
  logic            mem_req, mem_we, addr_src, ir_we, pc_we, reg_we;
  logic [1:0]      result_sel, a_sel, b_sel;
  logic [3:0]      alu_op;

  always_comb begin
    alu_f3_ok  = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) ||
                 (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    decode_nxt = S_TRAP;
    case (i_operand)
      OP_LOAD, OP_STORE: if (i_funct3 == 3'b010) decode_nxt = S_MEMADR;
      OP_R:    if (alu_f3_ok && !(i_funct7bit5 && (i_funct3 != 3'b000))) decode_nxt = S_EXECR;
      OP_I:    if (alu_f3_ok) decode_nxt = S_EXECI;
      OP_BR:   if ((i_funct3 == 3'b000) || (EXT_EN && (i_funct3 == 3'b001))) decode_nxt = S_BRANCH;
      OP_JAL:  decode_nxt = S_JAL;
      OP_JALR: if (EXT_EN) decode_nxt = S_JALR;
      OP_LUI:  if (EXT_EN) decode_nxt = S_LUI;
      default: decode_nxt = S_TRAP;
    endcase
  end

  always_comb begin
    case (i_funct3)
      3'b000:  exec_op = ((state_q == S_EXECR) && i_funct7bit5) ? ALU_SUB : ALU_ADD;
      3'b111:  exec_op = ALU_AND;
      3'b110:  exec_op = ALU_OR;
      3'b010:  exec_op = ALU_SLT;
      default: exec_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    tmo_d      = tmo_q;
    mem_wait   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    result_sel = RES_ALUOUT;
    a_sel      = A_PC;
    b_sel      = B_RD2;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        result_sel = RES_ALU;
        b_sel      = B_FOUR;
        if (i_memReady) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        a_sel   = A_OLDPC;
        b_sel   = B_IMM;
        state_d = decode_nxt;
        if (decode_nxt == S_TRAP) illegal_d = 1'b1;
      end
      S_MEMADR: begin
        a_sel   = A_RD1;
        b_sel   = B_IMM;
        state_d = i_operand[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (i_memReady) state_d = S_MEMWB;
        else            mem_wait = 1'b1;
      end
      S_MEMWB: begin
        result_sel = RES_DATA;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (i_memReady) state_d = S_FETCH;
        else            mem_wait = 1'b1;
      end
      S_EXECR: begin
        a_sel   = A_RD1;
        b_sel   = B_RD2;
        alu_op  = exec_op;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        a_sel   = A_RD1;
        b_sel   = B_IMM;
        alu_op  = exec_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        result_sel = RES_ALUOUT;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        a_sel   = A_RD1;
        b_sel   = B_RD2;
        alu_op  = ALU_SUB;
        // funct3[0] distinguishes bne from beq; only those two reach this state.
        pc_we   = i_funct3[0] ? !i_zeroFlag : i_zeroFlag;
        state_d = S_FETCH;
      end
      S_JAL: begin
        a_sel   = A_OLDPC;
        b_sel   = B_FOUR;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        a_sel      = A_RD1;
        b_sel      = B_IMM;
        result_sel = RES_ALU;
        pc_we      = 1'b1;
        state_d    = S_JALRLINK;
      end
      S_JALRLINK: begin
        a_sel      = A_OLDPC;
        b_sel      = B_FOUR;
        result_sel = RES_ALU;
        reg_we     = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        a_sel   = A_ZERO;
        b_sel   = B_IMM;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // A ready arriving on the limit cycle has already moved state_d on, so it wins.
    if ((TIMEOUT != 0) && mem_wait && (cnt_q == LIMIT)) begin
      state_d = S_TRAP;
      tmo_d   = 1'b1;
    end

    if ((state_d != state_q) || i_memReady) cnt_d = '0;
    else if (mem_wait)                      cnt_d = cnt_q + CW'(1);
    else                                    cnt_d = cnt_q;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  // Enables are masked during reset so an in-flight access is abandoned immediately.
  assign o_memReq              = mem_req & ~i_arst;
  assign o_memWriteEn          = mem_we  & ~i_arst;
  assign o_instructionRegWrite = ir_we   & ~i_arst;
  assign o_pcWriteEn           = pc_we   & ~i_arst;
  assign o_regWriteEn          = reg_we  & ~i_arst;
  assign o_addressSrc          = addr_src;
  assign o_resultSel           = result_sel;
  assign o_aluInputASel        = a_sel;
  assign o_aluInputBSel        = b_sel;
  assign o_aluLogicOperation   = alu_op;
  assign o_illegal             = illegal_q;
  assign o_memTimeout          = tmo_q;
  assign o_state               = state_q;

endmodule

// File: tb/tb_mcycle_controller.sv
// Scoreboard bench for mcycle_controller: per-cycle expected outputs are queued with their stimulus.
// Instance dut has EXT_EN=1/TIMEOUT=4, instance dut0 has the defaults (EXT_EN=0/TIMEOUT=16).
module tb_mcycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq;
    logic       mwe;
    logic       asrc;
    logic       irw;
    logic       pcw;
    logic       rgw;
    logic [1:0] rsel;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [3:0] op;
    logic       ill;
    logic       tmo;
  } obs_t;

  typedef struct packed {
    logic rdy;
    logic zf;
    logic sel;
    obs_t e;
  } step_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic       clk = 1'b0;
  logic       arst;
  logic [6:0] operand;
  logic [2:0] funct3;
  logic       f7b5;
  logic       zf;
  logic       memready;

  logic       a_memReq, a_memWriteEn, a_addressSrc, a_irWrite, a_pcWriteEn, a_regWriteEn;
  logic [1:0] a_resultSel, a_aSel, a_bSel;
  logic [3:0] a_op, a_state;
  logic       a_illegal, a_memTimeout;
  logic       b_memReq, b_memWriteEn, b_addressSrc, b_irWrite, b_pcWriteEn, b_regWriteEn;
  logic [1:0] b_resultSel, b_aSel, b_bSel;
  logic [3:0] b_op, b_state;
  logic       b_illegal, b_memTimeout;

  obs_t obs, obs0;
  step_t sq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcycle_controller #(.EXT_EN(1'b1), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_arst(arst), .i_operand(operand), .i_funct3(funct3),
    .i_funct7bit5(f7b5), .i_zeroFlag(zf), .i_memReady(memready),
    .o_memReq(a_memReq), .o_memWriteEn(a_memWriteEn), .o_addressSrc(a_addressSrc),
    .o_instructionRegWrite(a_irWrite), .o_pcWriteEn(a_pcWriteEn), .o_regWriteEn(a_regWriteEn),
    .o_resultSel(a_resultSel), .o_aluInputASel(a_aSel), .o_aluInputBSel(a_bSel),
    .o_aluLogicOperation(a_op), .o_illegal(a_illegal), .o_memTimeout(a_memTimeout),
    .o_state(a_state)
  );

  mcycle_controller dut0 (
    .i_clk(clk), .i_arst(arst), .i_operand(operand), .i_funct3(funct3),
    .i_funct7bit5(f7b5), .i_zeroFlag(zf), .i_memReady(memready),
    .o_memReq(b_memReq), .o_memWriteEn(b_memWriteEn), .o_addressSrc(b_addressSrc),
    .o_instructionRegWrite(b_irWrite), .o_pcWriteEn(b_pcWriteEn), .o_regWriteEn(b_regWriteEn),
    .o_resultSel(b_resultSel), .o_aluInputASel(b_aSel), .o_aluInputBSel(b_bSel),
    .o_aluLogicOperation(b_op), .o_illegal(b_illegal), .o_memTimeout(b_memTimeout),
    .o_state(b_state)
  );

  assign obs  = {a_state, a_memReq, a_memWriteEn, a_addressSrc, a_irWrite, a_pcWriteEn,
                 a_regWriteEn, a_resultSel, a_aSel, a_bSel, a_op, a_illegal, a_memTimeout};
  assign obs0 = {b_state, b_memReq, b_memWriteEn, b_addressSrc, b_irWrite, b_pcWriteEn,
                 b_regWriteEn, b_resultSel, b_aSel, b_bSel, b_op, b_illegal, b_memTimeout};

  // Expected-row builders, written straight from the per-state output table.
  function automatic obs_t r(input logic [3:0] st, input logic mreq, input logic mwe,
                             input logic asrc, input logic irw, input logic pcw, input logic rgw,
                             input logic [1:0] rsel, input logic [1:0] asel, input logic [1:0] bsel,
                             input logic [3:0] op, input logic ill, input logic tmo);
    return {st, mreq, mwe, asrc, irw, pcw, rgw, rsel, asel, bsel, op, ill, tmo};
  endfunction

  function automatic obs_t fetch(input logic rdy);
    return r(4'd0, 1, 0, 0, rdy, rdy, 0, 2'd2, 2'd0, 2'd2, 4'd0, 0, 0);
  endfunction
  function automatic obs_t decode();
    return r(4'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 4'd0, 0, 0);
  endfunction
  function automatic obs_t aluwb();
    return r(4'd8, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic obs_t memadr();
    return r(4'd2, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 4'd0, 0, 0);
  endfunction
  function automatic obs_t memread();
    return r(4'd3, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic obs_t memwrite();
    return r(4'd5, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 0);
  endfunction
  function automatic obs_t trap(input logic ill, input logic tmo);
    return r(4'd15, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, ill, tmo);
  endfunction

  task automatic push(input logic rdy, input logic z, input logic sel, input obs_t e);
    step_t s;
    s.rdy = rdy; s.zf = z; s.sel = sel; s.e = e;
    sq.push_back(s);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    operand = op; funct3 = f3; f7b5 = f7;
  endtask

  task automatic do_reset();
    arst = 1'b1; memready = 1'b0; zf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_reset();
    set_instr(OP_R, 3'b000, 1'b0);
    arst = 1'b1; memready = 1'b1; zf = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (a_state !== 4'd0 || b_state !== 4'd0) begin
      errors++; $display("FAIL reset_state got %0d/%0d want 0", a_state, b_state);
    end
    checks++;
    if ({a_memReq, a_irWrite, a_pcWriteEn, a_regWriteEn} !== 4'b0000) begin
      errors++; $display("FAIL reset_enables got %b want 0000", {a_memReq, a_irWrite, a_pcWriteEn, a_regWriteEn});
    end
    checks++;
    if ({a_illegal, a_memTimeout, b_illegal, b_memTimeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {a_illegal, a_memTimeout, b_illegal, b_memTimeout});
    end
    @(negedge clk);
    arst = 1'b0; memready = 1'b0;
    #1;
    checks++;
    if (a_memReq !== 1'b1 || a_state !== 4'd0) begin
      errors++; $display("FAIL first_fetch_req got req=%b st=%0d want req=1 st=0", a_memReq, a_state);
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    step_t s; obs_t got; obs_t mid; int k;
    for (int ci = 0; ci < 6; ci++) begin
      case (ci)
        0: begin set_instr(OP_R, 3'b000, 1'b0); mid = r(4'd6, 0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 4'd0, 0,0); end
        1: begin set_instr(OP_R, 3'b000, 1'b1); mid = r(4'd6, 0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 4'd1, 0,0); end
        2: begin set_instr(OP_R, 3'b111, 1'b0); mid = r(4'd6, 0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 4'd2, 0,0); end
        3: begin set_instr(OP_I, 3'b110, 1'b0); mid = r(4'd7, 0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 4'd3, 0,0); end
        4: begin set_instr(OP_I, 3'b010, 1'b1); mid = r(4'd7, 0,0,0,0,0,0, 2'd0, 2'd2, 2'd1, 4'd4, 0,0); end
        default: begin set_instr(OP_LUI, 3'b101, 1'b0); mid = r(4'd13, 0,0,0,0,0,0, 2'd0, 2'd3, 2'd1, 4'd0, 0,0); end
      endcase
      do_reset();
      push(1, 0, 0, fetch(1));
      push(0, 0, 0, decode());
      push(0, 0, 0, mid);
      push(0, 0, 0, aluwb());
      push(0, 0, 0, fetch(0));
      k = 0;
      while (sq.size() != 0) begin
        s = sq.pop_front();
        memready = s.rdy; zf = s.zf;
        #1;
        got = s.sel ? obs0 : obs;
        checks++;
        if (got !== s.e) begin
          errors++; $display("FAIL alu[%0d] step %0d got %h want %h", ci, k, got, s.e);
        end
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_mem();
    step_t s; obs_t got; int k;
    // lw with two wait cycles in FETCH and in MEMREAD
    set_instr(OP_LOAD, 3'b010, 1'b0);
    do_reset();
    push(0, 0, 0, fetch(0)); push(0, 0, 0, fetch(0)); push(1, 0, 0, fetch(1));
    push(0, 0, 0, decode()); push(0, 0, 0, memadr());
    push(0, 0, 0, memread()); push(0, 0, 0, memread()); push(1, 0, 0, memread());
    push(0, 0, 0, r(4'd4, 0,0,0,0,0,1, 2'd1, 2'd0, 2'd0, 4'd0, 0,0));
    push(0, 0, 0, fetch(0));
    k = 0;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      memready = s.rdy; zf = s.zf;
      #1;
      got = s.sel ? obs0 : obs;
      checks++;
      if (got !== s.e) begin
        errors++; $display("FAIL lw step %0d got %h want %h", k, got, s.e);
      end
      k++;
      @(negedge clk);
    end
    set_instr(OP_STORE, 3'b010, 1'b0);
    do_reset();
    push(1, 0, 0, fetch(1)); push(0, 0, 0, decode()); push(0, 0, 0, memadr());
    push(0, 0, 0, memwrite()); push(1, 0, 0, memwrite()); push(0, 0, 0, fetch(0));
    k = 0;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      memready = s.rdy; zf = s.zf;
      #1;
      got = s.sel ? obs0 : obs;
      checks++;
      if (got !== s.e) begin
        errors++; $display("FAIL sw step %0d got %h want %h", k, got, s.e);
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    step_t s; obs_t got; int k;
    logic [2:0] f3; logic z; logic taken;
    for (int ci = 0; ci < 5; ci++) begin
      f3 = (ci < 2) ? 3'b000 : 3'b001;
      z  = (ci == 0 || ci == 3) ? 1'b1 : 1'b0;
      taken = (ci == 0 || ci == 2) ? 1'b1 : 1'b0;
      set_instr(OP_BR, f3, 1'b0);
      do_reset();
      if (ci < 4) begin
        push(1, 0, 0, fetch(1));
        push(0, 0, 0, decode());
        push(0, z, 0, r(4'd9, 0,0,0,0, taken, 0, 2'd0, 2'd2, 2'd0, 4'd1, 0,0));
        push(0, 0, 0, fetch(0));
      end else begin
        // bne without the extension is illegal on the base-set instance
        push(1, 0, 1, fetch(1));
        push(0, 0, 1, decode());
        push(0, 0, 1, trap(1, 0));
        push(1, 1, 1, trap(1, 0));
      end
      k = 0;
      while (sq.size() != 0) begin
        s = sq.pop_front();
        memready = s.rdy; zf = s.zf;
        #1;
        got = s.sel ? obs0 : obs;
        checks++;
        if (got !== s.e) begin
          errors++; $display("FAIL branch[%0d] step %0d got %h want %h", ci, k, got, s.e);
        end
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump();
    step_t s; obs_t got; int k;
    for (int ci = 0; ci < 4; ci++) begin
      case (ci)
        0: set_instr(OP_JAL, 3'b011, 1'b0);
        1: set_instr(OP_JALR, 3'b000, 1'b0);
        2: set_instr(OP_JALR, 3'b000, 1'b0);
        default: set_instr(OP_LUI, 3'b000, 1'b0);
      endcase
      do_reset();
      if (ci == 0) begin
        push(1, 0, 0, fetch(1)); push(0, 0, 0, decode());
        push(0, 0, 0, r(4'd10, 0,0,0,0,1,0, 2'd0, 2'd1, 2'd2, 4'd0, 0,0));
        push(0, 0, 0, aluwb()); push(0, 0, 0, fetch(0));
      end else if (ci == 1) begin
        push(1, 0, 0, fetch(1)); push(0, 0, 0, decode());
        push(0, 0, 0, r(4'd11, 0,0,0,0,1,0, 2'd2, 2'd2, 2'd1, 4'd0, 0,0));
        push(0, 0, 0, r(4'd12, 0,0,0,0,0,1, 2'd2, 2'd1, 2'd2, 4'd0, 0,0));
        push(0, 0, 0, fetch(0));
      end else begin
        push(1, 0, 1, fetch(1)); push(0, 0, 1, decode());
        push(0, 0, 1, trap(1, 0)); push(0, 0, 1, trap(1, 0));
      end
      k = 0;
      while (sq.size() != 0) begin
        s = sq.pop_front();
        memready = s.rdy; zf = s.zf;
        #1;
        got = s.sel ? obs0 : obs;
        checks++;
        if (got !== s.e) begin
          errors++; $display("FAIL jump[%0d] step %0d got %h want %h", ci, k, got, s.e);
        end
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s; obs_t got; int k;
    for (int ci = 0; ci < 6; ci++) begin
      case (ci)
        0: set_instr(7'b1111111, 3'b000, 1'b0);
        1: set_instr(OP_LOAD, 3'b000, 1'b0);
        2: set_instr(OP_R, 3'b001, 1'b0);
        3: set_instr(OP_R, 3'b111, 1'b1);
        4: set_instr(OP_I, 3'b100, 1'b0);
        default: set_instr(OP_BR, 3'b100, 1'b0);
      endcase
      do_reset();
      push(1, 0, 0, fetch(1)); push(0, 0, 0, decode());
      push(1, 1, 0, trap(1, 0)); push(1, 0, 0, trap(1, 0));
      k = 0;
      while (sq.size() != 0) begin
        s = sq.pop_front();
        memready = s.rdy; zf = s.zf;
        #1;
        got = s.sel ? obs0 : obs;
        checks++;
        if (got !== s.e) begin
          errors++; $display("FAIL illegal[%0d] step %0d got %h want %h", ci, k, got, s.e);
        end
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s; obs_t got; int k;
    for (int ci = 0; ci < 5; ci++) begin
      case (ci)
        0, 1: set_instr(OP_R, 3'b000, 1'b0);
        2: set_instr(OP_LOAD, 3'b010, 1'b0);
        3: set_instr(OP_STORE, 3'b010, 1'b0);
        default: set_instr(OP_R, 3'b000, 1'b0);
      endcase
      do_reset();
      if (ci == 0) begin
        for (int i = 0; i < 4; i++) push(0, 0, 0, fetch(0));
        push(1, 0, 0, trap(0, 1)); push(0, 0, 0, trap(0, 1));
      end else if (ci == 1) begin
        for (int i = 0; i < 3; i++) push(0, 0, 0, fetch(0));
        push(1, 0, 0, fetch(1)); push(0, 0, 0, decode());
        push(0, 0, 0, r(4'd6, 0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 4'd0, 0,0));
      end else if (ci == 2) begin
        push(1, 0, 0, fetch(1)); push(0, 0, 0, decode()); push(0, 0, 0, memadr());
        for (int i = 0; i < 4; i++) push(0, 0, 0, memread());
        push(0, 0, 0, trap(0, 1));
      end else if (ci == 3) begin
        push(1, 0, 0, fetch(1)); push(0, 0, 0, decode()); push(0, 0, 0, memadr());
        for (int i = 0; i < 3; i++) push(0, 0, 0, memwrite());
        push(1, 0, 0, memwrite()); push(0, 0, 0, fetch(0));
      end else begin
        // default TIMEOUT of 16: ready on the 16th wait cycle is still accepted
        for (int i = 0; i < 15; i++) push(0, 0, 1, fetch(0));
        push(1, 0, 1, fetch(1)); push(0, 0, 1, decode());
      end
      k = 0;
      while (sq.size() != 0) begin
        s = sq.pop_front();
        memready = s.rdy; zf = s.zf;
        #1;
        got = s.sel ? obs0 : obs;
        checks++;
        if (got !== s.e) begin
          errors++; $display("FAIL timeout[%0d] step %0d got %h want %h", ci, k, got, s.e);
        end
        k++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    step_t s; obs_t got; int k;
    set_instr(7'b0000000, 3'b000, 1'b0);
    do_reset();
    push(1, 0, 0, fetch(1)); push(0, 0, 0, decode()); push(0, 0, 0, trap(1, 0));
    k = 0;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      memready = s.rdy; zf = s.zf;
      #1;
      got = s.sel ? obs0 : obs;
      checks++;
      if (got !== s.e) begin
        errors++; $display("FAIL rst_trap step %0d got %h want %h", k, got, s.e);
      end
      k++;
      @(negedge clk);
    end
    #2 arst = 1'b1;
    #1;
    checks++;
    if (a_illegal !== 1'b0 || a_state !== 4'd0) begin
      errors++; $display("FAIL rst_clears_trap got ill=%b st=%0d want ill=0 st=0", a_illegal, a_state);
    end
    set_instr(OP_STORE, 3'b010, 1'b0);
    do_reset();
    push(1, 0, 0, fetch(1)); push(0, 0, 0, decode()); push(0, 0, 0, memadr());
    push(0, 0, 0, memwrite()); push(0, 0, 0, memwrite());
    k = 0;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      memready = s.rdy; zf = s.zf;
      #1;
      got = s.sel ? obs0 : obs;
      checks++;
      if (got !== s.e) begin
        errors++; $display("FAIL rst_write step %0d got %h want %h", k, got, s.e);
      end
      k++;
      @(negedge clk);
    end
    memready = 1'b0;
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({a_memReq, a_memWriteEn} !== 2'b00 || a_state !== 4'd0 ||
        {a_illegal, a_memTimeout} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_write got req=%b we=%b st=%0d flags=%b want 0 0 0 00",
                         a_memReq, a_memWriteEn, a_state, {a_illegal, a_memTimeout});
    end
    @(negedge clk);
    arst = 1'b0;
    #1;
    checks++;
    if (a_memReq !== 1'b1 || a_memWriteEn !== 1'b0) begin
      errors++; $display("FAIL rst_refetch got req=%b we=%b want 1 0", a_memReq, a_memWriteEn);
    end
    @(negedge clk);
  endtask

  initial begin
    arst = 1'b1; memready = 1'b0; zf = 1'b0;
    operand = 7'd0; funct3 = 3'd0; f7b5 = 1'b0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
